// File: rtl/mac_seq_driver.sv
// Initiator for the mac_unit operand protocol: feeds K activation/weight pairs one at a time,
// chaining each MAC result back in as the next addend, and returns the final dot product.
module mac_seq_driver #(
  parameter int N       = 16,
  parameter int LEN_W   = 10,
  parameter int TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len_din,
  input  logic [31:0]      bias_din,
  input  logic             data_vld,
  output logic             data_rdy,
  input  logic [N-1:0]     act_din,
  input  logic [N-1:0]     wgt_din,
  output logic             addend_vld,
  output logic [31:0]      addend_dout,
  output logic             multiplicand_vld,
  output logic [N-1:0]     multiplicand_dout,
  output logic [N-1:0]     multiplier_dout,
  input  logic [31:0]      mac_din,
  input  logic             mac_din_vld,
  output logic [31:0]      result_dout,
  output logic             result_vld,
  output logic             busy,
  output logic             err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state_q;
  logic [31:0]      acc_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_inc_s;
  logic [TMR_W-1:0] tmr_q;
  logic             addend_vld_q;
  logic [31:0]      addend_dout_q;
  logic             multiplicand_vld_q;
  logic [N-1:0]     multiplicand_dout_q;
  logic [N-1:0]     multiplier_dout_q;
  logic [31:0]      result_dout_q;
  logic             result_vld_q;
  logic             err_q;

  assign cnt_inc_s = cnt_q + LEN_W'(1);

  // Sequencer: one operation in flight; operand registers hold between issues so the
  // multiplier stays stable while mac_unit samples it during WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      acc_q               <= 32'd0;
      len_q               <= '0;
      cnt_q               <= '0;
      tmr_q               <= '0;
      addend_vld_q        <= 1'b0;
      addend_dout_q       <= 32'd0;
      multiplicand_vld_q  <= 1'b0;
      multiplicand_dout_q <= '0;
      multiplier_dout_q   <= '0;
      result_dout_q       <= 32'd0;
      result_vld_q        <= 1'b0;
      err_q               <= 1'b0;
    end else begin
      addend_vld_q       <= 1'b0;
      multiplicand_vld_q <= 1'b0;
      result_vld_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= bias_din;
            len_q   <= len_din;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= (len_din != '0) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          if (data_vld) begin
            addend_vld_q        <= 1'b1;
            multiplicand_vld_q  <= 1'b1;
            addend_dout_q       <= acc_q;
            multiplicand_dout_q <= act_din;
            multiplier_dout_q   <= wgt_din;
            tmr_q               <= '0;
            state_q             <= WAIT;
          end
        end
        WAIT: begin
          if (mac_din_vld) begin
            acc_q   <= mac_din;
            cnt_q   <= cnt_inc_s;
            state_q <= (cnt_inc_s == len_q) ? DONE : ISSUE;
          end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            // Give up and report whatever partial sum has been accumulated.
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        DONE: begin
          result_vld_q  <= 1'b1;
          result_dout_q <= acc_q;
          state_q       <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_rdy          = (state_q == ISSUE);
  assign busy              = (state_q != IDLE);
  assign addend_vld        = addend_vld_q;
  assign addend_dout       = addend_dout_q;
  assign multiplicand_vld  = multiplicand_vld_q;
  assign multiplicand_dout = multiplicand_dout_q;
  assign multiplier_dout   = multiplier_dout_q;
  assign result_dout       = result_dout_q;
  assign result_vld        = result_vld_q;
  assign err               = err_q;

endmodule
